// File: rtl/dmem_if.sv
// Purpose : request/response bundle between a load/store requester and dmem_resp.
// Latency : n/a (signal bundle only).
// Backpressure: requester holds iReq and its payload stable until oAck pulses.
// Ports   : iReq/iWr/iAddr/iWrData (+iParInj when DMEM_PARITY_EN) from the requester,
//           oAck/oErr/oRdData/oBusy back from the responder.
// Option  : DMEM_PARITY_EN adds iParInj (flip the stored parity bit on a write).
interface dmem_if;
  logic        iReq;
  logic        iWr;
  logic [31:0] iAddr;
  logic [31:0] iWrData;
  logic        oAck;
  logic        oErr;
  logic [31:0] oRdData;
  logic        oBusy;
`ifdef DMEM_PARITY_EN
  logic        iParInj;

  modport master (output iReq, iWr, iAddr, iWrData, iParInj,
                  input  oAck, oErr, oRdData, oBusy);
  modport slave  (input  iReq, iWr, iAddr, iWrData, iParInj,
                  output oAck, oErr, oRdData, oBusy);
`else
  modport master (output iReq, iWr, iAddr, iWrData,
                  input  oAck, oErr, oRdData, oBusy);
  modport slave  (input  iReq, iWr, iAddr, iWrData,
                  output oAck, oErr, oRdData, oBusy);
`endif
endinterface

// File: rtl/dmem_resp.sv
// Purpose : data-memory responder; one access at a time, error on misaligned/out-of-range.
// Latency : oAck one cycle after edge accept+WAIT_CYC (WAIT_CYC wait states, 0..15).
// Backpressure: oBusy high in WAIT/RESP; requests are only sampled in IDLE.
// Ports   : clk, resetn (async, active-low), bus (dmem_if.slave).
// Option  : DMEM_PARITY_EN stores an even-parity bit per word; a read with a parity
//           mismatch acks with oErr=1 and returns the stored data.
module dmem_resp #(
  parameter int DEPTH    = 256,
  parameter int AW       = 8,
  parameter int WAIT_CYC = 2
) (
  input  logic   clk,
  input  logic   resetn,
  dmem_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q,   cnt_d;
  logic        wr_q,    wr_d;
  logic [31:0] addr_q,  addr_d;
  logic [31:0] wdat_q,  wdat_d;
  logic [31:0] rdat_q,  rdat_d;
  logic        err_q,   err_d;

  // Storage is deliberately not reset.
  logic [31:0] mem [DEPTH];

  // Commit-time source: with zero wait states the commit happens on the accept
  // edge itself, so the live inputs are used instead of the capture registers.
  logic        src_wr;
  logic [31:0] src_addr;
  logic [31:0] src_wdat;
  logic        addr_err;
  logic [AW-1:0] idx;
  logic        commit;
  logic        mem_we;

`ifdef DMEM_PARITY_EN
  logic             inj_q, inj_d;
  logic             src_inj;
  logic [DEPTH-1:0] par_mem;
  logic             par_bad;
`endif

  always_comb begin
    src_wr   = (state_q == S_IDLE) ? bus.iWr     : wr_q;
    src_addr = (state_q == S_IDLE) ? bus.iAddr   : addr_q;
    src_wdat = (state_q == S_IDLE) ? bus.iWrData : wdat_q;
    addr_err = (src_addr[1:0] != 2'b00) || (src_addr[31:AW+2] != '0);
    idx      = src_addr[AW+1:2];
  end

`ifdef DMEM_PARITY_EN
  always_comb begin
    src_inj = (state_q == S_IDLE) ? bus.iParInj : inj_q;
    par_bad = ((^mem[idx]) != par_mem[idx]);
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    rdat_d  = rdat_q;
    err_d   = err_q;
    commit  = 1'b0;
    mem_we  = 1'b0;
`ifdef DMEM_PARITY_EN
    inj_d   = inj_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.iReq) begin
          wr_d   = bus.iWr;
          addr_d = bus.iAddr;
          wdat_d = bus.iWrData;
`ifdef DMEM_PARITY_EN
          inj_d  = bus.iParInj;
`endif
          if (WAIT_CYC == 0) begin
            state_d = S_RESP;
            commit  = 1'b1;
          end else begin
            cnt_d   = 4'(WAIT_CYC);
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_RESP;
          commit  = 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        err_d   = 1'b0;   // oErr only means something alongside oAck
      end
      default: state_d = S_IDLE;
    endcase

    if (commit) begin
      if (addr_err) begin
        err_d  = 1'b1;
        rdat_d = '0;
      end else if (src_wr) begin
        err_d  = 1'b0;
        mem_we = resetn;  // never write while reset is held
      end else begin
        rdat_d = mem[idx];
`ifdef DMEM_PARITY_EN
        err_d  = par_bad;
`else
        err_d  = 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdat_q  <= '0;
      rdat_q  <= '0;
      err_q   <= 1'b0;
`ifdef DMEM_PARITY_EN
      inj_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
      err_q   <= err_d;
`ifdef DMEM_PARITY_EN
      inj_q   <= inj_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx] <= src_wdat;
`ifdef DMEM_PARITY_EN
      par_mem[idx] <= (^src_wdat) ^ src_inj;
`endif
    end
  end

  assign bus.oAck    = (state_q == S_RESP);
  assign bus.oBusy   = (state_q != S_IDLE);
  assign bus.oErr    = err_q;
  assign bus.oRdData = rdat_q;

endmodule

// File: doc/dmem_resp.md
Name: dmem_resp

Overview:
- Data-memory responder: the target end of the CPU's load/store memory port.
- Accepts one request at a time from the MEM stage (or any requester) over a req/ack handshake.
- Inserts a programmable number of wait states, then commits the write or returns read data.
- Flags misaligned and out-of-range accesses as errors.

Parameters:
- DEPTH, 256, number of 32-bit words stored.
- AW, 8, word-index width; must equal log2(DEPTH).
- WAIT_CYC, 2, wait states per access; legal range 0..15.

Ports:
- clk  input  1  system clock, rising edge.
- resetn  input  1  asynchronous, active-low reset.
- iReq  input  1  request valid; requester holds it with the other inputs stable until oAck.
- iWr  input  1  1 = write, 0 = read.
- iAddr  input  32  byte address.
- iWrData  input  32  write data.
- oAck  output  1  one-cycle completion pulse.
- oErr  output  1  error status, valid only while oAck=1.
- oRdData  output  32  read data, valid while oAck=1 on reads.
- oBusy  output  1  high while a request is in flight.

Behaviour:
- Single clock domain: clk.
- Reset is asynchronous and active-low (resetn); it takes effect immediately.
- Reset values: oAck=0, oErr=0, oBusy=0, oRdData=0, state=IDLE, wait counter=0.
- Memory array contents are not cleared by reset.
- FSM has three states: IDLE, WAIT, RESP.
- IDLE, oBusy=0:
  - iReq=1 at edge E0 captures iWr, iAddr and iWrData into internal registers.
  - WAIT_CYC>0: load counter=WAIT_CYC and go to WAIT.
  - WAIT_CYC=0: go directly to RESP.
- WAIT, oBusy=1:
  - Counter decrements each edge.
  - Counter==1 at an edge: go to RESP.
  - WAIT lasts exactly WAIT_CYC cycles.
- Commit happens on the edge that enters RESP, edge E0+WAIT_CYC:
  - Valid write: store captured data.
  - Valid read: register array[word index] into oRdData.
- RESP: oAck=1 and oBusy=1 for exactly one cycle, then IDLE unconditionally.
- Latency: oAck is high in the cycle after edge E0+WAIT_CYC.
- Inputs are ignored in WAIT and RESP.
- Back-to-back requests: a request is accepted on the first IDLE edge with iReq=1. Minimum spacing between accepts is WAIT_CYC+2 edges.
- Address decode:
  - Word index = iAddr[AW+1:2].
  - Error when iAddr[1:0]!=0 or iAddr[31:AW+2]!=0.
  - On error: no write, oRdData forced to 0, oErr=1 with oAck.
- oRdData holds its value until the next read ack, or until an error ack forces it to 0. Write acks leave it unchanged.
- Reset mid-operation:
  - If reset lands before the commit edge, the access is aborted and no write occurs.
  - FSM returns to IDLE with all outputs at reset values.

Optional Feature:
- Macro: DMEM_PARITY_EN.
- With the macro defined:
  - Each word gets an extra stored even-parity bit, computed at write commit.
  - An extra input port iParInj (1 bit) inverts the stored parity bit on that write, for test.
  - A read whose recomputed parity mismatches acks with oErr=1 and oRdData = the stored data (not forced to 0).
- Without the macro: no parity storage, no iParInj port, oErr reflects address errors only.

Test Plan:
- Reset: assert resetn=0 mid-run -> oAck=0, oErr=0, oBusy=0, oRdData=0 immediately, asynchronously.
- WAIT_CYC=2: write 0xDEADBEEF to 0x10, then read 0x10 -> each oAck lands 2 edges after accept, read returns oRdData=0xDEADBEEF with oErr=0, oBusy=1 during WAIT and RESP.
- Misaligned write of 0x12345678 to 0x13 -> oAck with oErr=1; subsequent read of 0x10 still returns 0xDEADBEEF.
- Out-of-range read at 0x400 (DEPTH=256) -> oErr=1, oRdData=0; changing iAddr during WAIT of a valid read at 0x10 has no effect, and it returns 0xDEADBEEF.
- Write 0xCAFE0000 to 0x20 with resetn pulsed low during WAIT -> no ack; a later read of 0x20 returns the prior value (preload 0x11111111); WAIT_CYC=0 gives ack on the first cycle after accept.
- DMEM_PARITY_EN: write 0xA5A5A5A5 to 0x30 with iParInj=1, then read -> oErr=1, oRdData=0xA5A5A5A5; rewrite with iParInj=0, then read -> oErr=0.
